// File: rtl/cc_line_refill.sv
// Cache miss refill engine: fetches one line with a single read burst, streams the
// beats into the data SRAM, then writes {valid, tag} into the tag SRAM.
module cc_line_refill #(
    parameter int TAG_W  = 18,
    parameter int IDX_W  = 8,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss_i,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [IDX_W-1:0]        index_i,
    output logic                    mem_arvalid_o,
    input  logic                    mem_arready_i,
    output logic [31:0]             mem_araddr_o,
    output logic [3:0]              mem_arlen_o,
    input  logic                    mem_rvalid_i,
    output logic                    mem_rready_o,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic [1:0]              mem_rresp_i,
    input  logic                    mem_rlast_i,
    output logic                    data_wren_o,
    output logic [IDX_W+2:0]        data_waddr_o,
    output logic [DATA_W-1:0]       data_wdata_o,
    output logic                    tag_wren_o,
    output logic [IDX_W-1:0]        tag_waddr_o,
    output logic [TAG_W:0]          tag_wdata_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_TAGW,
        ST_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cnt_at_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

    assign cnt_at_last = (cnt_q == CNT_LAST);
    assign mem_arlen_o = 4'(BEATS - 1);
    assign busy_o      = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        tag_d         = tag_q;
        idx_d         = idx_q;
        mem_arvalid_o = 1'b0;
        mem_araddr_o  = '0;
        mem_rready_o  = 1'b0;
        data_wren_o   = 1'b0;
        data_waddr_o  = '0;
        data_wdata_o  = '0;
        tag_wren_o    = 1'b0;
        tag_waddr_o   = '0;
        tag_wdata_o   = '0;
        done_o        = 1'b0;
        err_o         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (miss_i) begin
                    tag_d   = tag_i;
                    idx_d   = index_i;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_arvalid_o = 1'b1;
                mem_araddr_o  = 32'({tag_q, idx_q, OFF_W'(0)});
                if (mem_arready_i) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                mem_rready_o = 1'b1;
                if (mem_rvalid_i) begin
                    data_wren_o  = 1'b1;
                    data_waddr_o = {idx_q, cnt_q};
                    data_wdata_o = mem_rdata_i;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (mem_rresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    // A burst whose rlast disagrees with the beat count is malformed.
                    if (mem_rlast_i != cnt_at_last) begin
                        err_d = 1'b1;
                    end
                    if (mem_rlast_i || cnt_at_last) begin
                        state_d = ST_TAGW;
                    end
                end
            end
            ST_TAGW: begin
                tag_wren_o  = 1'b1;
                tag_waddr_o = idx_q;
                tag_wdata_o = {~err_q, tag_q};
                state_d     = ST_FIN;
            end
            ST_FIN: begin
                done_o  = ~err_q;
                err_o   = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cc_line_refill.sv
// Directed bench for cc_line_refill: clean fill, stalls, error beat, early rlast,
// ignored second miss and mid-refill reset.
module tb_cc_line_refill;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_i;
    logic [17:0] tag_i;
    logic [7:0]  index_i;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic        mem_rvalid_i;
    logic        mem_rready_o;
    logic [63:0] mem_rdata_i;
    logic [1:0]  mem_rresp_i;
    logic        mem_rlast_i;
    logic        data_wren_o;
    logic [10:0] data_waddr_o;
    logic [63:0] data_wdata_o;
    logic        tag_wren_o;
    logic [7:0]  tag_waddr_o;
    logic [18:0] tag_wdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    cc_line_refill dut (
        .clk(clk), .rst_n(rst_n), .miss_i(miss_i), .tag_i(tag_i), .index_i(index_i),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
        .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i), .mem_rlast_i(mem_rlast_i),
        .data_wren_o(data_wren_o), .data_waddr_o(data_waddr_o), .data_wdata_o(data_wdata_o),
        .tag_wren_o(tag_wren_o), .tag_waddr_o(tag_waddr_o), .tag_wdata_o(tag_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Write/pulse log filled on the falling edge, away from the active edge.
    logic [10:0] wr_addr [0:127];
    logic [63:0] wr_data [0:127];
    int          wr_n    = 0;
    int          tag_n   = 0;
    logic [7:0]  tag_addr_seen;
    logic [18:0] tag_data_seen;
    int          done_n  = 0;
    int          err_n   = 0;
    int          fin_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_wren_o && wr_n < 128) begin
            wr_addr[wr_n] = data_waddr_o;
            wr_data[wr_n] = data_wdata_o;
            wr_n = wr_n + 1;
        end
        if (tag_wren_o) begin
            tag_n = tag_n + 1;
            tag_addr_seen = tag_waddr_o;
            tag_data_seen = tag_wdata_o;
        end
        if (done_o) done_n = done_n + 1;
        if (err_o) err_n = err_n + 1;
        // Latency is taken to the rising edge that samples the pulse.
        if (done_o || err_o) fin_cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] pat(input int b);
        return 64'h1111_1111_1111_1111 * 64'(b + 1);
    endfunction

    int          wr_base, tag_base, done_base, err_base, miss_cyc;
    logic [31:0] araddr_seen;

    // Runs one refill: stall = arready-low cycles, gaps = idle cycles before beats 2/4/6,
    // err_beat = beat with SLVERR, last_beat = beat carrying rlast, miss2_beat = beat
    // during which a second miss is raised.
    task automatic run_refill(input logic [17:0] t, input logic [7:0] ix, input int stall,
                              input bit gaps, input int err_beat, input int last_beat,
                              input int miss2_beat);
        wr_base = wr_n; tag_base = tag_n; done_base = done_n; err_base = err_n;
        miss_i = 1'b1; tag_i = t; index_i = ix;
        miss_cyc = cyc;
        @(posedge clk); #1;
        miss_i = 1'b0; tag_i = '0; index_i = '0;
        for (int s = 0; s < stall; s++) begin
            chk("arvalid_held", 64'(mem_arvalid_o), 64'd1);
            chk("araddr_held", 64'(mem_araddr_o), 64'({t, ix, 6'b0}));
            @(posedge clk); #1;
        end
        araddr_seen = mem_araddr_o;
        chk("arlen", 64'(mem_arlen_o), 64'd7);
        mem_arready_i = 1'b1;
        @(posedge clk); #1;
        mem_arready_i = 1'b0;
        for (int b = 0; b <= last_beat; b++) begin
            if (gaps && (b == 2 || b == 4 || b == 6)) begin
                mem_rvalid_i = 1'b0;
                @(posedge clk); #1;
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pat(b);
            mem_rresp_i  = (b == err_beat) ? 2'b10 : 2'b00;
            mem_rlast_i  = (b == last_beat);
            miss_i       = (b == miss2_beat);
            tag_i        = (b == miss2_beat) ? 18'h11111 : 18'h0;
            index_i      = (b == miss2_beat) ? 8'h77 : 8'h0;
            @(posedge clk); #1;
        end
        mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; mem_rresp_i = 2'b00;
        miss_i = 1'b0; tag_i = '0; index_i = '0;
        for (int w = 0; w < 20 && (done_n + err_n) == (done_base + err_base); w++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_refill(input string nm, input logic [7:0] ix, input int nwr,
                                input logic [18:0] exp_tag, input int exp_done,
                                input int exp_err, input int exp_lat);
        chk({nm, "_nwrites"}, 64'(wr_n - wr_base), 64'(nwr));
        for (int i = 0; i < nwr; i++) begin
            chk({nm, "_waddr"}, 64'(wr_addr[wr_base + i]), 64'({ix, 3'(i)}));
            chk({nm, "_wdata"}, wr_data[wr_base + i], pat(i));
        end
        chk({nm, "_ntag"}, 64'(tag_n - tag_base), 64'd1);
        chk({nm, "_tag_addr"}, 64'(tag_addr_seen), 64'(ix));
        chk({nm, "_tag_data"}, 64'(tag_data_seen), 64'(exp_tag));
        chk({nm, "_done"}, 64'(done_n - done_base), 64'(exp_done));
        chk({nm, "_err"}, 64'(err_n - err_base), 64'(exp_err));
        chk({nm, "_latency"}, 64'(fin_cyc - miss_cyc), 64'(exp_lat));
        chk({nm, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; miss_i = 1'b0; tag_i = '0; index_i = '0;
        mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        mem_rresp_i = 2'b00; mem_rlast_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_arvalid", 64'(mem_arvalid_o), 64'd0);
        chk("rst_arlen", 64'(mem_arlen_o), 64'd7);
        chk("rst_outs", 64'({mem_rready_o, data_wren_o, tag_wren_o, done_o, err_o}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean fill: address 0x2A5A5<<14 | 0x3C<<6 = 0xA9694F00, valid tag 0x6A5A5.
        run_refill(18'h2A5A5, 8'h3C, 0, 1'b0, -1, 7, -1);
        chk("clean_araddr", 64'(araddr_seen), 64'h0000_0000_A969_4F00);
        check_refill("clean", 8'h3C, 8, 19'h6A5A5, 1, 0, 12);

        // Backpressure: 5 arready-low cycles plus 3 rvalid gaps -> 12 + 8.
        run_refill(18'h00F0F, 8'h81, 5, 1'b1, -1, 7, -1);
        check_refill("stall", 8'h81, 8, 19'h40F0F, 1, 0, 20);

        // SLVERR on beat 3: all beats still written, tag left invalid.
        run_refill(18'h2A5A5, 8'h3C, 0, 1'b0, 3, 7, -1);
        check_refill("rresp_err", 8'h3C, 8, 19'h2A5A5, 0, 1, 12);

        // Early rlast on beat 5: six writes, error, shorter by two beats.
        run_refill(18'h3FFFF, 8'hFF, 0, 1'b0, -1, 5, -1);
        check_refill("early_last", 8'hFF, 6, 19'h3FFFF, 0, 1, 10);

        // Second miss during beat 2 must not disturb the captured tag/index.
        run_refill(18'h12345, 8'h05, 0, 1'b0, -1, 7, 2);
        check_refill("miss2", 8'h05, 8, 19'h52345, 1, 0, 12);

        // Reset in the middle of the data phase abandons the refill.
        tag_base = tag_n; done_base = done_n; err_base = err_n;
        miss_i = 1'b1; tag_i = 18'h0ABCD; index_i = 8'h42;
        @(posedge clk); #1;
        miss_i = 1'b0; mem_arready_i = 1'b1;
        @(posedge clk); #1;
        mem_arready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = pat(b);
            @(posedge clk); #1;
        end
        chk("mid_busy", 64'(busy_o), 64'd1);
        mem_rvalid_i = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", 64'(busy_o), 64'd0);
        chk("mrst_outs", 64'({mem_arvalid_o, mem_rready_o, data_wren_o, tag_wren_o,
                              done_o, err_o}), 64'd0);
        chk("mrst_araddr", 64'(mem_araddr_o), 64'd0);
        chk("mrst_arlen", 64'(mem_arlen_o), 64'd7);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("mrst_no_tag", 64'(tag_n - tag_base), 64'd0);
        chk("mrst_no_fin", 64'((done_n - done_base) + (err_n - err_base)), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
